instruction_fetch: RTL and testbench

Upstream fetch stage of the single-cycle RISC-V core. Owns the program counter, issues word reads to instruction memory over a valid/ready request and a valid response, and presents one captured instruction at a time to the decode/control stage. On retire, it advances the PC to PC+4 or to the resolved branch/jump target. It holds the core in a benign state (NOP presented) while fetching, and halts on a misaligned target.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/next_pc_gen.sv | 28 ++
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : addi x0,x0,0, presented when no fetched instruction is valid
//   fetch_state_t : fetch sequencer states
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC computation for the fetch stage.
// Ports:
//   pc_i            : address of the current instruction
//   branch_taken_i  : current instruction redirects the PC
//   branch_target_i : redirect address (ALU result)
//   next_pc_o       : PC of the following instruction
//   pc_plus_four_o  : pc_i + 4 (wraps mod 2^32), also used for link write-back
//   misaligned_o    : next_pc_o is not word-aligned
module next_pc_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] pc_plus_four_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] target_clr;

  // jalr semantics: the redirect target always has bit 0 cleared.
  assign target_clr     = branch_target_i & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign pc_plus_four_o = pc_i + {{(XLEN-3){1'b0}}, 3'd4};
  assign next_pc_o      = branch_taken_i ? target_clr : pc_plus_four_o;
  assign misaligned_o   = |next_pc_o[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the single-cycle RISC-V core.
// Owns the PC, requests one word per instruction from instruction memory
// (valid/ready request, valid-only response), presents the captured word to
// decode, and advances the PC when the execute stage retires the instruction.
// A misaligned next PC parks the stage in a terminal fault state.
// Ports:
//   clk, resetn                  : clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr : fetch request channel
//   imem_rsp_valid, imem_rsp_data   : fetch response channel
//   stall                        : execute not finished, blocks retire
//   branch_taken, branch_target  : redirect, sampled at the retire edge
//   instr_valid, instruction     : decoded instruction (NOP when not valid)
//   pc, pc_plus_four             : address of current instruction and +4
//   fetch_fault                  : sticky misaligned-target flag
//   retired_count                : retired instruction counter (wraps)
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four,
  output logic        fetch_fault,
  output logic [31:0] retired_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         retire;

  next_pc_gen u_next_pc_gen (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc),
    .pc_plus_four_o  (pc_plus_four),
    .misaligned_o    (misaligned)
  );

  assign retire = (state_q == S_EXEC) && !stall;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_EXEC;
      S_EXEC:  if (!stall)         state_d = misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_REQ;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    if ((state_q == S_WAIT) && imem_rsp_valid) begin
      instr_d = imem_rsp_data;
    end
    // A faulting retire still counts, but the PC stays on the offending
    // instruction so software can see where the bad redirect came from.
    if (retire) begin
      count_d = count_q + 32'd1;
      if (!misaligned) begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Outputs decoded from state only; resetn gates them so the reset cycle
  // itself never shows a request or a valid instruction.
  always_comb begin
    imem_req_valid = resetn && (state_q == S_REQ);
    instr_valid    = resetn && (state_q == S_EXEC);
    fetch_fault    = resetn && (state_q == S_FAULT);
    instruction    = instr_valid ? instr_q : NOP_INSTR;
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic        fetch_fault;
  logic [31:0] retired_count;

  instruction_fetch dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .pc             (pc),
    .pc_plus_four   (pc_plus_four),
    .fetch_fault    (fetch_fault),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          ready_gap;  // cycles of imem_req_ready=0 before acceptance
    int          rsp_gap;    // extra cycles of response delay beyond the minimum
    int          stall_n;    // stall cycles in S_EXEC
    bit          br;
    logic [31:0] tgt;
    logic [31:0] exp_pc;     // expected fetch address / pc
    logic [31:0] exp_next;   // expected next fetch address
    bit          exp_fault;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_count = 0;
  int last_req_cyc = 0;
  int exp_spacing = 0;
  bit have_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // One full instruction: request, response, optional stall, retire.
  task automatic do_instr(input vec_t v);
    int start;
    start = cyc;
    if (have_prev) chk("spacing", cyc - last_req_cyc, exp_spacing);
    last_req_cyc = cyc;
    have_prev = 1;
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("imem_addr", imem_addr, v.exp_pc);
    chk("req_instr_nop", instruction, NOP);
    imem_req_ready = 1'b0;
    for (int i = 0; i < v.ready_gap; i++) begin
      tick();
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr_hold", imem_addr, v.exp_pc);
      chk("bp_instr_nop", instruction, NOP);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_req_low", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < v.rsp_gap; i++) begin
      chk("wait_invalid", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("wait_nop", instruction, NOP);
    end
    chk("wait_invalid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word_for(v.exp_pc);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    chk("exec_latency", cyc - start, 32'(2 + v.ready_gap + v.rsp_gap));
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instruction", instruction, word_for(v.exp_pc));
    chk("pc", pc, v.exp_pc);
    chk("pc_plus_four", pc_plus_four, v.exp_pc + 32'd4);
    chk("retired_count", retired_count, 32'(model_count));
    // Redirect inputs are don't-care while stalled; drive junk to prove it.
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0102;
    for (int i = 0; i < v.stall_n; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, v.exp_pc);
      chk("stall_instr", instruction, word_for(v.exp_pc));
      chk("stall_count", retired_count, 32'(model_count));
    end
    stall = 1'b0;
    branch_taken = v.br;
    branch_target = v.tgt;
    tick();
    branch_taken = 1'b0;
    branch_target = 32'h0;
    model_count++;
    chk("retire_count", retired_count, 32'(model_count));
    chk("fault", {31'd0, fetch_fault}, {31'd0, v.exp_fault});
    chk("post_instr_valid", {31'd0, instr_valid}, 32'd0);
    if (v.exp_fault) begin
      chk("fault_req_low", {31'd0, imem_req_valid}, 32'd0);
      chk("fault_pc_held", pc, v.exp_pc);
    end else begin
      chk("next_pc", pc, v.exp_next);
    end
    exp_spacing = 3 + v.ready_gap + v.rsp_gap + v.stall_n;
    $display("instr pc=%h br=%0d tgt=%h -> pc=%h fault=%0d count=%0d",
             v.exp_pc, v.br, v.tgt, pc, fetch_fault, retired_count);
  endtask

  task automatic apply_reset(input int n);
    resetn = 1'b0;
    #0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    end
    resetn = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_req_after", {31'd0, imem_req_valid}, 32'd1);
    model_count = 0;
    have_prev = 0;
    $display("reset released at cycle %0d", cyc);
  endtask

  vec_t vecs[11];
  vec_t v;

  initial begin
    //                rdy rsp stl br  tgt            pc             next           fault
    vecs[0]  = '{0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0004, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0008, 0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h0000_000C, 0};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,         32'h0000_000C, 32'h0000_0010, 0};
    vecs[4]  = '{3, 1, 0, 0, 32'h0,         32'h0000_0010, 32'h0000_0014, 0};
    vecs[5]  = '{0, 0, 5, 0, 32'h0,         32'h0000_0014, 32'h0000_0018, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h0000_0100, 32'h0000_0018, 32'h0000_0100, 0};
    vecs[7]  = '{0, 0, 0, 1, 32'h0000_0205, 32'h0000_0100, 32'h0000_0204, 0};
    vecs[8]  = '{0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0204, 32'hFFFF_FFFC, 0};
    vecs[9]  = '{0, 2, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 0};
    vecs[10] = '{0, 0, 0, 1, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 1};

    #1;
    chk("rst0_req_valid", {31'd0, imem_req_valid}, 32'd0);
    apply_reset(2);

    foreach (vecs[i]) do_instr(vecs[i]);

    // Fault is terminal: no requests, nothing retires, even with ready/response.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("fault_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_count", retired_count, 32'(model_count));
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    $display("fault hold checked, count=%0d", retired_count);

    apply_reset(1);

    // Run one instruction, then reset in the middle of S_WAIT of the next.
    v = '{0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
    do_instr(v);
    chk("mid_addr", imem_addr, 32'h4);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("mid_wait_req_low", {31'd0, imem_req_valid}, 32'd0);
    resetn = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    tick();
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    resetn = 1'b1;
    // Stale response arriving in S_REQ must be ignored.
    tick();
    chk("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("stale_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_pc", pc, 32'h0);
    chk("stale_count", retired_count, 32'd0);
    chk("stale_instr", instruction, NOP);
    imem_rsp_valid = 1'b0;
    model_count = 0;
    have_prev = 0;
    $display("mid-wait reset and stale response checked");
    do_instr(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
